// File: rtl/pwm_pkg.sv
// Shared PWM types: capture FSM states, default counter width and the count type
// also used by the PWM generators.
package pwm_pkg;

    localparam int PWM_CNT_W = 16;

    typedef logic [PWM_CNT_W-1:0] pwm_count_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_cap_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Input conditioning for pwm_capture: synchronizer, optional debounce filter
// (enabled by PWM_CAPTURE_FILTER_EN) and rise/fall detector.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_prev_q, level_prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FCNT_W = $clog2(FILTER_LEN + 1);

    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        level_prev_d = level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            sync_q       <= '0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            level_prev_q <= level_prev_d;
        end
    end

    assign rise = level & ~level_prev_q;
    assign fall = ~level & level_prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures period and high time between consecutive rises of pwm_in.
// Build option: define PWM_CAPTURE_FILTER_EN to insert the input debounce filter.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic level, rise, fall;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    pwm_cap_state_e   state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q, timeout_d;
    logic             stuck_level_q, stuck_level_d;

    always_comb begin
        state_d       = state_q;
        period_cnt_d  = period_cnt_q;
        high_cnt_d    = high_cnt_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        meas_valid_d  = 1'b0;
        timeout_d     = 1'b0;
        stuck_level_d = stuck_level_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d      = HIGH;
                    period_cnt_d = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                end
            end

            HIGH: begin
                // Saturation wins over any edge seen in the same cycle.
                if (period_cnt_q == CNT_MAX) begin
                    state_d       = IDLE;
                    timeout_d     = 1'b1;
                    stuck_level_d = level;
                end else begin
                    period_cnt_d = period_cnt_q + CNT_ONE;
                    if (fall) begin
                        state_d = LOW;
                    end else begin
                        high_cnt_d = high_cnt_q + CNT_ONE;
                    end
                end
            end

            LOW: begin
                if (period_cnt_q == CNT_MAX) begin
                    state_d       = IDLE;
                    timeout_d     = 1'b1;
                    stuck_level_d = level;
                end else if (rise) begin
                    state_d      = HIGH;
                    period_d     = period_cnt_q;
                    high_time_d  = high_cnt_q;
                    meas_valid_d = 1'b1;
                    period_cnt_d = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                end else begin
                    period_cnt_d = period_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            period_cnt_q  <= '0;
            high_cnt_q    <= '0;
            period_q      <= '0;
            high_time_q   <= '0;
            meas_valid_q  <= 1'b0;
            timeout_q     <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            high_cnt_q    <= high_cnt_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            meas_valid_q  <= meas_valid_d;
            timeout_q     <= timeout_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_time_q;
    assign meas_valid  = meas_valid_q;
    assign timeout     = timeout_q;
    assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture: a 16-bit instance for measurement,
// reset and glitch tests and an 8-bit instance for the saturation test.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm16, pwm8;
    logic [15:0] period16, high16;
    logic [7:0]  period8, high8;
    logic        mv16, to16, stuck16;
    logic        mv8, to8, stuck8;

    int errors = 0;
    int checks = 0;

    int p16_q[$], h16_q[$], p8_q[$], h8_q[$];
    int to16_cnt = 0;
    int to8_cnt  = 0;
    int lat;
    int exp_p2[6] = '{100, 100, 100, 100, 2, 2};
    int exp_h2[6] = '{1, 1, 99, 99, 1, 1};

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int DET_LAT = 2 + 4 + 1;
`else
    localparam int DET_LAT = 2 + 1;
`endif

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(16), .SYNC_STAGES(2), .FILTER_LEN(4)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm16),
        .period      (period16),
        .high_time   (high16),
        .meas_valid  (mv16),
        .timeout     (to16),
        .stuck_level (stuck16)
    );

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(2), .FILTER_LEN(4)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm8),
        .period      (period8),
        .high_time   (high8),
        .meas_valid  (mv8),
        .timeout     (to8),
        .stuck_level (stuck8)
    );

    always @(negedge clk) begin
        if (mv16) begin
            p16_q.push_back(int'(period16));
            h16_q.push_back(int'(high16));
        end
        if (mv8) begin
            p8_q.push_back(int'(period8));
            h8_q.push_back(int'(high8));
        end
        if (to16) to16_cnt++;
        if (to8)  to8_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_meas(input bit sel8, input string tag, input int idx,
                              input int ep, input int eh);
        int gp, gh;
        if (sel8) begin
            gp = (idx < p8_q.size()) ? p8_q[idx] : -1;
            gh = (idx < h8_q.size()) ? h8_q[idx] : -1;
        end else begin
            gp = (idx < p16_q.size()) ? p16_q[idx] : -1;
            gh = (idx < h16_q.size()) ? h16_q[idx] : -1;
        end
        check($sformatf("%s_period[%0d]", tag, idx), gp, ep);
        check($sformatf("%s_high[%0d]", tag, idx), gh, eh);
    endtask

    task automatic clear_q();
        p16_q.delete();
        h16_q.delete();
        p8_q.delete();
        h8_q.delete();
    endtask

    // One or more PWM cycles, starting right after a falling clock edge.
    task automatic wave(input bit sel8, input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel8) pwm8 = 1'b1; else pwm16 = 1'b1;
            repeat (h) @(negedge clk);
            if (sel8) pwm8 = 1'b0; else pwm16 = 1'b0;
            repeat (l) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pwm16 = 1'b0;
        pwm8  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        pwm16 = 1'b0;
        pwm8  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period",    32'(period16), 0);
        check("rst_high",      32'(high16),   0);
        check("rst_valid",     32'(mv16),     0);
        check("rst_timeout",   32'(to16),     0);
        check("rst_stuck",     32'(stuck16),  0);
        check("rst_period8",   32'(period8),  0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 25% duty, three cycles: two strobes
        clear_q();
        wave(1'b0, 64, 192, 3);
        repeat (10) @(negedge clk);
        check("t1_count", p16_q.size(), 2);
        for (int i = 0; i < 2; i++) check_meas(1'b0, "t1", i, 256, 64);
        check("t1_last_period", 32'(period16), 256);

        // Async reset mid-HIGH, away from any clock edge
        pwm16 = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_period",  32'(period16), 0);
        check("t4_high",    32'(high16),   0);
        check("t4_valid",   32'(mv16),     0);
        check("t4_timeout", 32'(to16),     0);
        check("t4_stuck",   32'(stuck16),  0);
        pwm16 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        clear_q();
        wave(1'b0, 30, 70, 1);
        check("t4_first_rise_no_strobe", p16_q.size(), 0);
        wave(1'b0, 30, 70, 1);
        repeat (10) @(negedge clk);
        check("t4_count", p16_q.size(), 1);
        check_meas(1'b0, "t4", 0, 100, 30);

        // Line change: 100/1, 100/99, then the minimum 2/1 period
        do_reset();
        clear_q();
        wave(1'b0, 1, 99, 2);
        wave(1'b0, 99, 1, 2);
        wave(1'b0, 1, 1, 3);
        repeat (10) @(negedge clk);
        check("t2_count", p16_q.size(), 6);
        for (int i = 0; i < 6; i++) check_meas(1'b0, "t2", i, exp_p2[i], exp_h2[i]);

        // Stuck high on the 8-bit instance
        clear_q();
        to8_cnt = 0;
        lat = 0;
        pwm8 = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (to8) begin
                lat = k;
                break;
            end
        end
        check("t3_timeout_latency", lat, DET_LAT + 255);
        check("t3_stuck_level", 32'(stuck8), 1);
        check("t3_period_kept", 32'(period8), 0);
        check("t3_no_strobe", p8_q.size(), 0);
        @(negedge clk);
        check("t3_timeout_one_cycle", 32'(to8), 0);
        check("t3_timeout_count", to8_cnt, 1);
        pwm8 = 1'b0;
        repeat (5) @(negedge clk);
        wave(1'b1, 25, 25, 3);
        repeat (10) @(negedge clk);
        check("t3_resume_count", p8_q.size(), 2);
        for (int i = 0; i < 2; i++) check_meas(1'b1, "t3", i, 50, 25);

        // 200/50 waveform with a 2-cycle glitch inside each low phase
        do_reset();
        clear_q();
        for (int i = 0; i < 3; i++) begin
            wave(1'b0, 50, 100, 1);
            wave(1'b0, 2, 48, 1);
        end
        repeat (15) @(negedge clk);
`ifdef PWM_CAPTURE_FILTER_EN
        check("t5_count", p16_q.size(), 2);
        for (int i = 0; i < 2; i++) check_meas(1'b0, "t5", i, 200, 50);
`else
        check("t5_count", p16_q.size(), 5);
        check_meas(1'b0, "t5", 0, 150, 50);
        check_meas(1'b0, "t5", 1, 50, 2);
        check_meas(1'b0, "t5", 2, 150, 50);
`endif

        check("no_timeout16", to16_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
PWM decoder. Samples a PWM waveform, such as the output of the team's RGB/LED PWM generators, and measures its period and high time in clk cycles. Publishes each complete measurement with a one-cycle valid strobe. Sits in loopback and self-test paths next to the PWM generators in top, and is also used on external PWM inputs.

Parameters:
CNT_W, 16, width of the period and high-time counters and outputs
SYNC_STAGES, 2, flops in the input synchronizer (minimum 2)
FILTER_LEN, 4, consecutive agreeing samples required by the glitch filter (used only with the macro)

Ports:
clk  input  1  system clock (12 MHz on board)
rst_n  input  1  asynchronous active-low reset
pwm_in  input  1  asynchronous PWM input
period  output  CNT_W  last measured period in clk cycles
high_time  output  CNT_W  last measured high time in clk cycles
meas_valid  output  1  one-cycle strobe when period/high_time update
timeout  output  1  one-cycle strobe when a counter saturates
stuck_level  output  1  synchronized level at the last timeout

Behaviour:
- Reset: one clock (clk), asynchronous active-low reset (rst_n). All flops clear when rst_n is low, regardless of clk.
  - Output reset values: period=0, high_time=0, meas_valid=0, timeout=0, stuck_level=0, state=IDLE.
  - Synchronizer flops reset to 0.
  - Reset mid-measurement discards the partial measurement. No strobe is issued.
- Input path: pwm_in passes through SYNC_STAGES flops, then an edge-detect flop giving rise/fall pulses. A pwm_in transition is detected SYNC_STAGES+1 clk edges later.
- FSM states and transitions:
  - IDLE: wait for a rise. On rise: go to HIGH, period_cnt=1, high_cnt=1.
  - HIGH: both counters increment. On fall: go to LOW, high_cnt holds.
  - LOW: period_cnt increments.
    - On rise: load period<=period_cnt and high_time<=high_cnt, pulse meas_valid for 1 cycle.
    - Then restart: period_cnt=1, high_cnt=1, go to HIGH.
    - A measurement therefore covers exactly the distance between two consecutive detected rises.
- Outputs are registered. meas_valid rises on the clk edge after the detected rise cycle, and period/high_time are stable from that same edge.
- The first rise after reset or timeout produces no strobe; the first strobe comes at the second rise.
- Saturation:
  - If period_cnt would exceed 2^CNT_W-1 in HIGH or LOW: pulse timeout for 1 cycle, set stuck_level to the synchronized level, go to IDLE.
  - period and high_time keep their previous values.
  - A rise arriving in that same cycle is ignored; the next rise restarts the measurement.
- Width rules: counters are unsigned CNT_W bits and never wrap. high_time <= period always holds.
- Simultaneous rise and fall in one cycle cannot occur after the edge detector. A one-cycle-wide pulse gives high_cnt=1.
- Short period: minimum measurable period is 2 cycles (high=1, low=1).

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- With the macro:
  - A FILTER_LEN-sample majority-free debounce sits between the synchronizer and the edge detector.
  - The filtered level changes only after FILTER_LEN consecutive identical samples.
  - Detection latency becomes SYNC_STAGES+FILTER_LEN+1 cycles. Pulses shorter than FILTER_LEN cycles are suppressed.
- Without the macro: no filter logic is instantiated and latency is SYNC_STAGES+1.

Decomposition:
- Package pwm_pkg holds:
  - enum pwm_cap_state_e {IDLE, HIGH, LOW};
  - default CNT_W constant;
  - a typedef for the count type, shared with the PWM generators.
- One sub-module: pwm_sync_edge. It contains the synchronizer, the optional filter and the rise/fall detector, with outputs level, rise and fall.

Test Plan:
1. 25% duty: period 256 cycles, high 64, three cycles of stimulus -> meas_valid pulses 2 times; period=256, high_time=64 each time.
2. Line change: period 100/high 1, then period 100/high 99 -> high_time=1 then 99, period=100 both times. Then period 2/high 1 -> period=2, high_time=1.
3. Stuck high: CNT_W=8, pwm_in held 1 after a rise -> timeout pulse exactly 255 cycles after rise detection, stuck_level=1, no meas_valid; a subsequent 50-cycle PWM resumes reporting from the second rise.
4. Reset: assert rst_n=0 mid-HIGH with no clk edge -> all outputs 0 immediately. After release, the first strobe appears only at the second rise.
5. Filter (with PWM_CAPTURE_FILTER_EN, FILTER_LEN=4): 2-cycle glitches injected in a 200/50 waveform -> period=200, high_time=50 unchanged. Without the macro, the same stimulus produces extra strobes with period<200.
